// File: rtl/dmem_pipe.sv
// Pipelined byte-addressable data memory for the MEM stage: sized loads/stores with a registered read.
// Build option: DMEM_MISALIGN_TRAP_EN rejects misaligned H/W accesses; otherwise addresses are aligned down.
module dmem_pipe #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH) + 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              wren,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              rvalid,
    output logic              err
);
    localparam int IDX_W = ADDR_W - 2;

    // Handshake: a request is sampled on every rising edge where req=1; its outcome
    // (rvalid or err) is a one-cycle pulse on the following cycle, with no back-pressure.

    logic [31:0] mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [1:0]       off_eff;
    logic             f3_legal;
    logic             misalign;
    logic             acc_ok;
    logic             store_ok;
    logic             load_ok;
    logic [3:0]       be;
    logic [31:0]      wdata;

    logic [31:0] rword_d, rword_q;
    logic [1:0]  off_d, off_q;
    logic [2:0]  f3_d, f3_q;
    logic        rvalid_d, rvalid_q;
    logic        err_d, err_q;

    always_comb begin
        idx      = address[ADDR_W-1:2];
        off_eff  = address[1:0];
        f3_legal = 1'b0;
        misalign = 1'b0;
        be       = 4'b0000;
        wdata    = data_in;
        case (funct3)
            3'b000, 3'b100: begin
                f3_legal = 1'b1;
                be       = 4'b0001 << address[1:0];
                wdata    = {4{data_in[7:0]}};
            end
            3'b001, 3'b101: begin
                f3_legal = 1'b1;
                misalign = address[0];
                off_eff  = {address[1], 1'b0};
                be       = 4'b0011 << off_eff;
                wdata    = {2{data_in[15:0]}};
            end
            3'b010: begin
                f3_legal = 1'b1;
                misalign = |address[1:0];
                off_eff  = 2'b00;
                be       = 4'b1111;
            end
            default: ;
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        acc_ok = f3_legal && !misalign;
`else
        acc_ok = f3_legal;
`endif
        store_ok = req && acc_ok && !wren && !reset;
        load_ok  = req && acc_ok && wren;

        // Word buffer, offset and size only move on an accepted load, which is what
        // keeps data_out stable across stores, idles and rejected requests.
        rword_d  = load_ok ? mem[idx] : rword_q;
        off_d    = load_ok ? off_eff : off_q;
        f3_d     = load_ok ? funct3 : f3_q;
        rvalid_d = load_ok;
        err_d    = req && !acc_ok;
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (store_ok && be[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rword_q  <= '0;
            off_q    <= '0;
            f3_q     <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rword_q  <= rword_d;
            off_q    <= off_d;
            f3_q     <= f3_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    logic [31:0] shifted;

    always_comb begin
        shifted = rword_q >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  data_out = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  data_out = {24'h0, shifted[7:0]};
            3'b001:  data_out = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  data_out = {16'h0, shifted[15:0]};
            default: data_out = rword_q;
        endcase
    end

    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe: sized stores/loads, hold behaviour, illegal/misaligned requests and reset.
// Expectations follow DMEM_MISALIGN_TRAP_EN when it is defined for the build.
module tb_dmem_pipe;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = $clog2(DEPTH) + 2;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;
    localparam logic       ST   = 1'b0;
    localparam logic       LD   = 1'b1;

    logic              clock;
    logic              reset;
    logic              req;
    logic              wren;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] address;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic              rvalid;
    logic              err;

    int n_cmp;
    int n_fail;

    dmem_pipe #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .wren     (wren),
        .funct3   (funct3),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .rvalid   (rvalid),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input logic v, input logic e);
        chk({tag, ".data_out"}, data_out, d);
        chk({tag, ".rvalid"}, {31'h0, rvalid}, {31'h0, v});
        chk({tag, ".err"}, {31'h0, err}, {31'h0, e});
    endtask

    // Drive one request across one rising edge; outputs are then sampled 1 time unit later.
    task automatic access(input logic rq, input logic wr, input logic [2:0] f3,
                          input logic [ADDR_W-1:0] a, input logic [31:0] d);
        req     = rq;
        wren    = wr;
        funct3  = f3;
        address = a;
        data_in = d;
        @(posedge clock);
        #1;
        req = 1'b0;
    endtask

    logic [31:0] w10;

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        reset   = 1'b1;
        req     = 1'b0;
        wren    = 1'b1;
        funct3  = 3'b000;
        address = '0;
        data_in = '0;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk_out("reset", 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

        access(1'b1, ST, F_W, 12'h010, 32'hDEADBEEF);
        chk_out("sw_dead", 32'h0, 1'b0, 1'b0);
        access(1'b1, LD, F_W, 12'h010, 32'h0);
        chk_out("lw_dead", 32'hDEADBEEF, 1'b1, 1'b0);

        access(1'b1, ST, F_W, 12'h010, 32'h11223344);
        access(1'b1, ST, F_B, 12'h013, 32'hFFFFFF80);
        chk_out("sb_hold", 32'hDEADBEEF, 1'b0, 1'b0);
        access(1'b1, LD, F_B, 12'h013, 32'h0);
        chk_out("lb_13", 32'hFFFFFF80, 1'b1, 1'b0);
        access(1'b1, LD, F_BU, 12'h013, 32'h0);
        chk_out("lbu_13", 32'h00000080, 1'b1, 1'b0);
        access(1'b1, LD, F_W, 12'h010, 32'h0);
        chk_out("lw_merge_b", 32'h80223344, 1'b1, 1'b0);

        access(1'b1, ST, F_H, 12'h012, 32'h12348001);
        access(1'b1, LD, F_H, 12'h012, 32'h0);
        chk_out("lh_12", 32'hFFFF8001, 1'b1, 1'b0);
        access(1'b1, LD, F_HU, 12'h012, 32'h0);
        chk_out("lhu_12", 32'h00008001, 1'b1, 1'b0);
        access(1'b1, LD, F_W, 12'h010, 32'h0);
        chk_out("lw_merge_h", 32'h80013344, 1'b1, 1'b0);
        w10 = 32'h80013344;

        access(1'b1, LD, F_W, 12'h011, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk_out("lw_mis", w10, 1'b0, 1'b1);
        access(1'b1, ST, F_W, 12'h012, 32'hCAFEF00D);
        chk_out("sw_mis", w10, 1'b0, 1'b1);
        access(1'b1, LD, F_H, 12'h013, 32'h0);
        chk_out("lh_mis", w10, 1'b0, 1'b1);
`else
        chk_out("lw_mis", w10, 1'b1, 1'b0);
        access(1'b1, ST, F_W, 12'h012, 32'hCAFEF00D);
        chk_out("sw_mis", w10, 1'b0, 1'b0);
        w10 = 32'hCAFEF00D;
        access(1'b1, LD, F_H, 12'h013, 32'h0);
        chk_out("lh_mis", 32'hFFFFCAFE, 1'b1, 1'b0);
`endif
        access(1'b1, LD, F_W, 12'h010, 32'h0);
        chk_out("lw_after_mis", w10, 1'b1, 1'b0);

        access(1'b1, ST, F_W, 12'h020, 32'h55667788);
        access(1'b1, ST, 3'b011, 12'h020, 32'hFFFFFFFF);
        chk_out("st_illegal", w10, 1'b0, 1'b1);
        access(1'b1, LD, 3'b110, 12'h020, 32'h0);
        chk_out("ld_illegal", w10, 1'b0, 1'b1);
        access(1'b1, LD, F_W, 12'h020, 32'h0);
        chk_out("lw_20", 32'h55667788, 1'b1, 1'b0);

        access(1'b0, LD, F_W, 12'h020, 32'h0);
        chk_out("idle", 32'h55667788, 1'b0, 1'b0);

        access(1'b1, LD, F_H, 12'h022, 32'h0);
        chk_out("b2b_lh", 32'h00005566, 1'b1, 1'b0);
        access(1'b1, LD, F_B, 12'h021, 32'h0);
        chk_out("b2b_lb", 32'h00000077, 1'b1, 1'b0);
        access(1'b1, LD, F_BU, 12'h023, 32'h0);
        chk_out("b2b_lbu", 32'h00000055, 1'b1, 1'b0);

        access(1'b1, ST, F_B, 12'h020, 32'h000000AA);
        access(1'b1, LD, F_W, 12'h020, 32'h0);
        chk_out("raw_merge", 32'h556677AA, 1'b1, 1'b0);

        reset = 1'b1;
        access(1'b1, ST, F_W, 12'h020, 32'h00000000);
        chk_out("rst_store", 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        access(1'b1, LD, F_W, 12'h020, 32'h0);
        chk_out("lw_after_rst", 32'h556677AA, 1'b1, 1'b0);

        reset = 1'b1;
        access(1'b1, LD, F_W, 12'h020, 32'h0);
        chk_out("rst_load", 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

        access(1'b1, LD, F_W, 12'h010, 32'h0);
        chk_out("pre_rst_load", w10, 1'b1, 1'b0);
        reset = 1'b1;
        access(1'b0, LD, F_W, 12'h010, 32'h0);
        chk_out("rst_override", 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        access(1'b1, ST, F_H, 12'h010, 32'h0000BEEF);
        access(1'b1, LD, F_W, 12'h010, 32'h0);
        chk_out("lw_final", {w10[31:16], 16'hBEEF}, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_pipe.md
# dmem_pipe

Pipelined, byte-addressable data memory for the segmented (pipelined) datapath. It is the parametrised successor of the single-cycle word RAM. It adds a registered read with a valid flag, RISC-V byte/half/word load/store sizing with sign/zero extension, and an error flag for misaligned or illegal accesses. It sits in the MEM stage, fed by the EX/MEM pipeline register, and drives the MEM/WB register.

## Interface
- DEPTH, 1024, number of 32-bit words; power of two, ≥ 4
- ADDR_W, $clog2(DEPTH)+2, byte-address width

- clock  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-high reset
- req  in  1  access request, sampled at the rising edge
- wren  in  1  active-low write enable, matching the control unit: 0 = store, 1 = load (meaningful only when req=1)
- funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU; any other value is illegal
- address  in  ADDR_W  byte address; word index address[ADDR_W-1:2], lane offset address[1:0]
- data_in  in  32  store data, right-aligned
- data_out  out  32  load result, extended to 32 bits
- rvalid  out  1  data_out carries the result of the load sampled on the previous edge
- err  out  1  the previous-edge request was misaligned or illegal

## Operation
- Single port: one access per cycle, either a load or a store. The array is DEPTH×32 with per-byte write enables.
- Store, accepted when req=1, wren=0, funct3 legal and aligned:
  - SB writes lane offset with data_in[7:0].
  - SH writes lanes offset and offset+1 with data_in[15:0].
  - SW writes all four lanes with data_in.
  - Lanes not written are preserved.
- Load, accepted when req=1, wren=1, funct3 legal and aligned:
  - The word is read into a registered word buffer; funct3 and offset are also registered.
  - data_out is the byte or half extracted from the registered word and offset.
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
- Alignment: H/HU require address[0]=0; W requires address[1:0]=00. B/BU are always aligned.
- Rejected request (misaligned or illegal funct3): no memory write, rvalid=0 next cycle, err=1 next cycle, data_out holds its previous value.
- data_out holds the last load result until the next accepted load. Stores and idle cycles do not change it.
- rvalid and err are single-cycle pulses per request.
- Memory contents are not cleared by reset and are undefined until written.

## Timing
- Reset values: data_out=0, rvalid=0, err=0. The registered offset and funct3 are cleared to 0.
- Load latency is 1: a load sampled at edge k gives rvalid=1 and valid data_out after edge k, until edge k+1.
- Throughput is one access per cycle. Back-to-back loads give rvalid high continuously.
- A store is committed at edge k. A load sampled at edge k+1 of the same word returns the new data (read-after-write, no stall).
- A load sampled at edge k+1 directly after a store at edge k to a different lane of the same word returns the merged word.
- reset=1 at an edge has priority over everything:
  - A store sampled in that cycle is suppressed (memory unchanged).
  - A load sampled in that cycle produces no rvalid.
  - A load issued the cycle before reset asserts has its rvalid overridden to 0.
- After reset deasserts, the first request is accepted at the next edge.
- req=0: no access; rvalid=0 and err=0 next cycle. wren, funct3 and address are don't-care.
- Address wrap-around cannot occur: ADDR_W spans exactly DEPTH words.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - Alignment is checked as described under Operation.
  - A misaligned request is rejected and err pulses.
- DMEM_MISALIGN_TRAP_EN undefined:
  - No alignment check. H/HU use offset with bit 0 forced to 0; W uses offset 00 (the address is aligned down).
  - err pulses only for illegal funct3.

## Test plan
- Reset, then SW 0xDEADBEEF @0x10, then LW @0x10 at the next edge -> after the load edge rvalid=1, data_out=0xDEADBEEF, err=0.
- SB 0x80 @0x13 over the word 0x11223344 @0x10, then LB @0x13 and LBU @0x13 -> 0xFFFFFF80 then 0x00000080; LW @0x10 -> 0x80223344.
- SH 0x8001 @0x12, then LH @0x12 and LHU @0x12 -> 0xFFFF8001 then 0x00008001; lanes 0–1 unchanged.
- LW @0x11 with DMEM_MISALIGN_TRAP_EN -> err=1, rvalid=0, data_out unchanged.
  - Without the macro -> rvalid=1 with the word @0x10.
  - SW @0x12 with the macro -> memory unchanged.
- funct3=011, store to @0x20 -> err=1 and word @0x20 unchanged.
  - Then a store at edge k with reset=1 in the same cycle -> memory unchanged.
  - A load issued one cycle before reset -> rvalid=0; data_out=0 after reset.
